// File: rtl/goodness_ema_multicore_pkg.sv
// Shared types and helpers for the multicore goodness EMA.
// Holds the width helpers, the FSM state type and the saturating accumulator add.
package goodness_pkg;

    typedef enum logic {
        ACCUM  = 1'b0,
        UPDATE = 1'b1
    } goodness_state_e;

    // A ReLU'd signed lane never needs its sign bit.
    function automatic int lane_width(input int mem_w);
        return mem_w - 1;
    endfunction

    function automatic int sum_width(input int mem_w, input int lanes);
        return lane_width(mem_w) + $clog2(lanes);
    endfunction

    function automatic int total_width(input int mem_w, input int lanes, input int cores);
        return sum_width(mem_w, lanes) + $clog2(cores);
    endfunction

    // Clamp a + b to 2^width-1; sat reports that the clamp was applied.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input int width, output logic sat);
        logic [64:0] sum_full;
        logic [64:0] max_val;
        sum_full = {1'b0, a} + {1'b0, b};
        max_val  = (65'd1 << width) - 65'd1;
        sat      = (sum_full > max_val);
        return sat ? 64'(max_val) : 64'(sum_full);
    endfunction

endpackage

// File: rtl/goodness_ema_multicore_if.sv
// Core-side bus of the goodness EMA: per-core membrane beats in, goodness results out.
interface goodness_ema_multicore_if #(
    parameter int CORE_NUM            = 2,
    parameter int POST_NEUR_PARALLEL  = 8,
    parameter int POST_NEUR_MEM_WIDTH = 13,
    parameter int GOODNESS_WIDTH      = 20
);
    logic [CORE_NUM-1:0]                                         CORE_VALID;
    logic [CORE_NUM*POST_NEUR_PARALLEL*POST_NEUR_MEM_WIDTH-1:0] CORE_MEM_BUS;
    logic                                                        CORE_CLEAR;
    logic [GOODNESS_WIDTH-1:0]                                   SAMPLE_GOODNESS;
    logic [GOODNESS_WIDTH-1:0]                                   AVG_GOODNESS;
    logic                                                        AVG_VALID;
    logic                                                        SAT_FLAG;
    logic                                                        EXTRA_BEAT;

    modport master (
        output CORE_VALID, CORE_MEM_BUS, CORE_CLEAR,
        input  SAMPLE_GOODNESS, AVG_GOODNESS, AVG_VALID, SAT_FLAG, EXTRA_BEAT
    );

    modport slave (
        input  CORE_VALID, CORE_MEM_BUS, CORE_CLEAR,
        output SAMPLE_GOODNESS, AVG_GOODNESS, AVG_VALID, SAT_FLAG, EXTRA_BEAT
    );
endinterface

// File: rtl/goodness_ema_multicore_lane_reduce.sv
// goodness_lane_reduce: ReLU of one core's lanes and a registered lane adder tree.
// With GOODNESS_SQUARE_EN defined, lanes are squared and registered before the tree.
module goodness_lane_reduce
    import goodness_pkg::*;
#(
    parameter int  POST_NEUR_PARALLEL  = 8,
    parameter int  POST_NEUR_MEM_WIDTH = 13,
    localparam int LANE_W = lane_width(POST_NEUR_MEM_WIDTH),
    localparam int SUM_W  = sum_width(POST_NEUR_MEM_WIDTH, POST_NEUR_PARALLEL)
) (
    input  logic                                              CLK,
    input  logic                                              RST_N,
    input  logic                                              flush,
    input  logic                                              in_valid,
    input  logic [POST_NEUR_PARALLEL*POST_NEUR_MEM_WIDTH-1:0] mem_bus,
    output logic                                              busy,
    output logic                                              out_valid,
    output logic [SUM_W-1:0]                                  out_sum
);
    localparam int W = POST_NEUR_MEM_WIDTH;

    logic [LANE_W-1:0] relu    [POST_NEUR_PARALLEL];
    logic [LANE_W-1:0] tree_in [POST_NEUR_PARALLEL];
    logic              tree_valid;
    logic [SUM_W-1:0]  tree_sum;

    always_comb begin
        for (int l = 0; l < POST_NEUR_PARALLEL; l++) begin
            relu[l] = mem_bus[l*W + W-1] ? '0 : mem_bus[l*W +: W-1];
        end
    end

    always_comb begin
        // NOTE: assigning a default before the loop keeps this block free of latches.
        tree_sum = '0;
        for (int l = 0; l < POST_NEUR_PARALLEL; l++) begin
            tree_sum = tree_sum + SUM_W'(tree_in[l]);
        end
    end

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) out_valid <= 1'b0;
        else        out_valid <= tree_valid & ~flush;
    end

    // NOTE: datapath registers are qualified by their valid bit, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (tree_valid) out_sum <= tree_sum;
    end

`ifdef GOODNESS_SQUARE_EN
    logic [LANE_W-1:0] sq_q [POST_NEUR_PARALLEL];
    logic              sq_valid;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) sq_valid <= 1'b0;
        else        sq_valid <= in_valid & ~flush;
    end

    // Keep the top half of the square so the lane width is unchanged.
    always_ff @(posedge CLK) begin
        for (int l = 0; l < POST_NEUR_PARALLEL; l++) begin
            sq_q[l] <= LANE_W'(({{LANE_W{1'b0}}, relu[l]} * {{LANE_W{1'b0}}, relu[l]})
                               >> (POST_NEUR_MEM_WIDTH - 1));
        end
    end

    assign tree_in    = sq_q;
    assign tree_valid = sq_valid;
    assign busy       = out_valid | sq_valid;
`else
    assign tree_in    = relu;
    assign tree_valid = in_valid;
    assign busy       = out_valid;
`endif

endmodule

// File: rtl/goodness_ema_multicore.sv
// Multicore goodness averager: per-sample goodness over all cores feeding a seeded EMA.
// GOODNESS_SQUARE_EN selects squared lanes (one extra pipeline stage) instead of ReLU.
module goodness_ema_multicore
    import goodness_pkg::*;
#(
    parameter int CORE_NUM            = 2,
    parameter int POST_NEUR_PARALLEL  = 8,
    parameter int POST_NEUR_MEM_WIDTH = 13,
    parameter int GOODNESS_WIDTH      = 20,
    parameter int BEATS_PER_SAMPLE    = 32,
    parameter int EMA_SHIFT           = 3
) (
    input logic                     CLK,
    input logic                     RST_N,
    goodness_ema_multicore_if.slave bus
);
    localparam int SLICE_W = POST_NEUR_PARALLEL * POST_NEUR_MEM_WIDTH;
    localparam int SUM_W   = sum_width(POST_NEUR_MEM_WIDTH, POST_NEUR_PARALLEL);
    localparam int TOT_W   = total_width(POST_NEUR_MEM_WIDTH, POST_NEUR_PARALLEL, CORE_NUM);
    localparam int CNT_W   = $clog2(BEATS_PER_SAMPLE + 1);
    localparam int GW      = GOODNESS_WIDTH;
    localparam logic [CNT_W-1:0] BEATS_L = CNT_W'(BEATS_PER_SAMPLE);
    localparam logic [GW-1:0]    G_MAX   = '1;

    goodness_state_e     state;
    logic [CNT_W-1:0]    cnt      [CORE_NUM];
    logic [SUM_W-1:0]    core_sum [CORE_NUM];
    logic [CORE_NUM-1:0] accept, drop, done, core_valid, core_busy;
    logic [TOT_W-1:0]    total;
    logic [GW-1:0]       acc, acc_add, avg, avg_ema, sample;
    logic                sat_hit, seeded, avg_valid, sat_flag, extra_beat;
    logic signed [GW:0]   ema_diff, ema_step;
    logic signed [GW+1:0] ema_sum;

    for (genvar c = 0; c < CORE_NUM; c++) begin : g_core
        goodness_lane_reduce #(
            .POST_NEUR_PARALLEL (POST_NEUR_PARALLEL),
            .POST_NEUR_MEM_WIDTH(POST_NEUR_MEM_WIDTH)
        ) u_reduce (
            .CLK      (CLK),
            .RST_N    (RST_N),
            .flush    (bus.CORE_CLEAR),
            .in_valid (accept[c]),
            .mem_bus  (bus.CORE_MEM_BUS[c*SLICE_W +: SLICE_W]),
            .busy     (core_busy[c]),
            .out_valid(core_valid[c]),
            .out_sum  (core_sum[c])
        );
    end

    always_comb begin
        total = '0;
        for (int c = 0; c < CORE_NUM; c++) begin
            done[c]   = (cnt[c] == BEATS_L);
            // During UPDATE the counters restart, so a beat there opens the next sample.
            accept[c] = bus.CORE_VALID[c] & ~bus.CORE_CLEAR & ((state == UPDATE) | ~done[c]);
            drop[c]   = bus.CORE_VALID[c] & ~bus.CORE_CLEAR & (state == ACCUM) & done[c];
            if (core_valid[c]) total = total + TOT_W'(core_sum[c]);
        end
        acc_add  = GW'(sat_add(64'(acc), 64'(total), GW, sat_hit));

        ema_diff = $signed({1'b0, acc}) - $signed({1'b0, avg});
        ema_step = ema_diff >>> EMA_SHIFT;
        ema_sum  = $signed({2'b00, avg}) + $signed({ema_step[GW], ema_step});
        if (ema_sum[GW+1])  avg_ema = '0;
        else if (ema_sum[GW]) avg_ema = G_MAX;
        else                avg_ema = ema_sum[GW-1:0];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= ACCUM;
            acc        <= '0;
            avg        <= '0;
            sample     <= '0;
            seeded     <= 1'b0;
            avg_valid  <= 1'b0;
            sat_flag   <= 1'b0;
            extra_beat <= 1'b0;
            for (int c = 0; c < CORE_NUM; c++) cnt[c] <= '0;
        end else begin
            avg_valid <= (state == UPDATE);
            // The result write completes even when a clear lands in the UPDATE cycle.
            if (state == UPDATE) begin
                sample <= acc;
                avg    <= seeded ? avg_ema : acc;
                seeded <= 1'b1;
            end

            if (bus.CORE_CLEAR) begin
                state      <= ACCUM;
                acc        <= '0;
                sat_flag   <= 1'b0;
                extra_beat <= 1'b0;
                for (int c = 0; c < CORE_NUM; c++) cnt[c] <= '0;
            end else if (state == UPDATE) begin
                state <= ACCUM;
                acc   <= '0;
                for (int c = 0; c < CORE_NUM; c++) cnt[c] <= accept[c] ? CNT_W'(1) : '0;
            end else begin
                if ((&done) && !(|core_busy)) state <= UPDATE;
                if (|core_valid) begin
                    acc      <= acc_add;
                    sat_flag <= sat_flag | sat_hit;
                end
                extra_beat <= extra_beat | (|drop);
                for (int c = 0; c < CORE_NUM; c++) begin
                    if (accept[c]) cnt[c] <= cnt[c] + CNT_W'(1);
                end
            end
        end
    end

    assign bus.SAMPLE_GOODNESS = sample;
    assign bus.AVG_GOODNESS    = avg;
    assign bus.AVG_VALID       = avg_valid;
    assign bus.SAT_FLAG        = sat_flag;
    assign bus.EXTRA_BEAT      = extra_beat;

endmodule

// File: doc/goodness_ema_multicore.md
Name: goodness_ema_multicore

Overview:
- Parametrised successor to the single-core goodness averager.
- Collects post-neuron membrane beats from CORE_NUM ODIN_ffstdp cores and reduces each core's POST_NEUR_PARALLEL lanes.
- Accumulates one per-sample goodness across all cores, then updates a seeded exponential moving average.
- The average drives AVG_GOODNESS of every core for FF positive/negative thresholding.

Parameters:
- CORE_NUM, 2: number of cores feeding beats.
- POST_NEUR_PARALLEL, 8: lanes per beat per core.
- POST_NEUR_MEM_WIDTH, 13: signed lane width.
- GOODNESS_WIDTH, 20: unsigned accumulator, sample and average width.
- BEATS_PER_SAMPLE, 32: beats per core per sample, equal to OUTPUT_NEURON/POST_NEUR_PARALLEL.
- EMA_SHIFT, 3: EMA weight 2^-EMA_SHIFT. Must be at least 1.

Ports:
- CLK, input, 1: clock.
- RST_N, input, 1: reset.
- CORE_VALID, input, CORE_NUM: per-core beat strobe.
- CORE_MEM_BUS, input, CORE_NUM*POST_NEUR_PARALLEL*POST_NEUR_MEM_WIDTH: core c at slice c, lane l within slice.
- CORE_CLEAR, input, 1: abort the current sample and restart collection.
- SAMPLE_GOODNESS, output, GOODNESS_WIDTH: last completed sample goodness.
- AVG_GOODNESS, output, GOODNESS_WIDTH: moving average.
- AVG_VALID, output, 1: one-cycle pulse on each average update.
- SAT_FLAG, output, 1: sticky; the accumulator saturated.
- EXTRA_BEAT, output, 1: sticky; a core delivered more than BEATS_PER_SAMPLE beats.

Behaviour:
- Clock and reset: one clock, CLK. RST_N is asynchronous and active-low.
- Reset values: all outputs 0, seeded=0, accumulator 0, beat counters 0, pipeline valid bits 0, state ACCUM.
- Stage 0 (edge t): for each core c with CORE_VALID[c]=1 and cnt[c] < BEATS_PER_SAMPLE:
  - lane value = max(mem,0), unsigned 12 bits;
  - register the lane sum for core c;
  - increment cnt[c].
- Stage 0 overflow: a beat arriving with cnt[c] = BEATS_PER_SAMPLE is dropped and sets EXTRA_BEAT.
- Stage 1 (edge t+1): sum the valid core sums and add them into the accumulator.
  - Saturate at 2^GOODNESS_WIDTH-1 and set SAT_FLAG on saturation.
- States: ACCUM and UPDATE.
- ACCUM→UPDATE: when every cnt[c] = BEATS_PER_SAMPLE and both pipeline stages are empty.
- UPDATE (one cycle), then →ACCUM:
  - SAMPLE_GOODNESS <= acc;
  - if seeded=0: AVG <= acc and seeded <= 1;
  - else: AVG <= AVG + ((acc - AVG) >>> EMA_SHIFT), signed difference one bit wider, result clamped to [0, max];
  - AVG_VALID=1 for this cycle only;
  - acc <= 0 and cnt <= 0.
- Beat timing: a beat accepted during UPDATE counts toward the next sample (cnt becomes 1). It reaches the accumulator after the clear, so it is not lost.
- Latency: the last beat at edge t gives AVG_VALID high in the cycle after edge t+3. AVG and SAMPLE_GOODNESS update on that same edge.
- CORE_CLEAR (any state):
  - acc, cnt and pipeline valid bits go to 0; state → ACCUM;
  - EXTRA_BEAT and SAT_FLAG are cleared;
  - AVG, seeded and SAMPLE_GOODNESS are kept;
  - it has priority over a same-cycle CORE_VALID, whose beat is dropped;
  - if it occurs during UPDATE, the UPDATE write still completes.
- Cores are unsynchronised: any subset may be valid in a given cycle, and cores may finish in any order.

Optional Feature:
- Macro: GOODNESS_SQUARE_EN.
- When defined, the lane value is max(mem,0)^2 >> (POST_NEUR_MEM_WIDTH-1), with width unchanged, plus one extra pipeline register after the squarers. Latency becomes edge t+4.
- When undefined, the lane value is the ReLU value and latency is t+3.

Decomposition:
- Package goodness_pkg holds:
  - lane/sum width functions (clog2-based);
  - the state enum {ACCUM, UPDATE};
  - the saturating-add function.
- One sub-module, goodness_lane_reduce: ReLU (optionally square) plus a registered adder tree for one core, instantiated CORE_NUM times.

Test Plan:
- Basic sample, CORE_NUM=2, BEATS=4, all lanes = +10: 8 beats → SAMPLE_GOODNESS=640, AVG=640 (seed), AVG_VALID pulse 3 cycles after the last beat.
- EMA update, EMA_SHIFT=3: after AVG=640, a second sample with lanes = -5 gives acc=0 → AVG=640-80=560. A third sample with lanes = +20 gives acc=1280 → AVG=560+90=650.
- Saturation, GOODNESS_WIDTH=12: lanes = 4095 → acc clamps at 4095, SAT_FLAG=1; CORE_CLEAR → SAT_FLAG=0.
- CORE_CLEAR mid-sample: 3 of 4 beats, clear coincident with a valid beat → no AVG_VALID. The next 8 clean beats give a normal result and AVG is unchanged until then.
- Skewed cores: core 1 finishes 10 cycles after core 0, and core 0 sends a 5th beat → EXTRA_BEAT=1, sum excludes the extra beat, single AVG_VALID.
- Back-to-back samples: core 0 beat arrives during the UPDATE cycle → counted in the next sample, whose SAMPLE_GOODNESS includes it.
